ttrng_collector: RTL and testbench
==================================

# ttrng_collector

Consumer side of the SR-latch TRNG entropy source. Samples the raw random bit stream on a strobe, runs a repetition-count health test on the raw bits, and removes bias with a von Neumann extractor. It packs the debiased bits into bytes and delivers them through a small show-ahead FIFO using a valid/ready handshake.

## Interface
- `RCT_LIMIT`, default 16: number of consecutive identical raw bits that trips the health test (range 2..255).
- `FIFO_DEPTH`, default 4: number of output byte entries. Must be a power of two, 2..16.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `raw_bit` input 1: raw entropy bit from the TRNG core.
- `raw_valid` input 1: `raw_bit` is sampled on cycles where this is 1.
- `clear_fail` input 1: one-cycle pulse that clears the health failure and flushes collector state.
- `byte_out` output 8: head of the FIFO. Valid only while `byte_valid` is 1.
- `byte_valid` output 1: the FIFO is non-empty.
- `byte_ready` input 1: consumer accepts `byte_out` on cycles where `byte_valid & byte_ready`.
- `health_fail` output 1: sticky health-test failure flag.
- `fifo_level` output clog2(FIFO_DEPTH)+1: current number of bytes in the FIFO.
- `drop_cnt` output 8: saturating count of bytes dropped because the FIFO was full.

## Operation
- **Reset values.** On reset, all outputs are 0, `byte_out` is 0x00, and the FIFO is empty. The pair holder, bit count, shift register, and run counter are also cleared.
- **Pair stage.** Accepted samples are consumed in pairs `(a, b)`, where `a` is the first sample.
  - If `a != b`, emit bit `a`: pair 1,0 emits 1 and pair 0,1 emits 0.
  - If `a == b`, discard the pair.
  - Pairing restarts after every second sample. Pairs never overlap.
- **Pack stage.** Each emitted bit shifts in as `shreg <= {shreg[6:0], bit}`, so the first emitted bit ends up as the MSB.
  - On the 8th bit, the completed byte is pushed to the FIFO and the bit count returns to 0.
- **FIFO push rules.**
  - If the FIFO is not full, push the byte.
  - If the FIFO is full and a pop happens in the same cycle, the push is still accepted and the level is unchanged.
  - If the FIFO is full with no pop, drop the byte and increment `drop_cnt`, saturating at 255.
- **FIFO pop rule.** A pop occurs when `byte_valid & byte_ready`. Popping an empty FIFO does nothing.
- **Repetition count test.**
  - `run_len` is updated on every accepted sample: it is set to 1 if `raw_bit` differs from the previous sample, otherwise incremented, saturating at `RCT_LIMIT`. The first sample after reset or clear sets it to 1.
  - When `run_len` reaches `RCT_LIMIT`, `health_fail` is set.
  - That sample is not passed to the pair stage.
- **While `health_fail` = 1.**
  - `raw_valid` is ignored and no pushes occur.
  - FIFO pops continue, so already-buffered bytes can drain.
- **`clear_fail` = 1.**
  - Clears `health_fail`, the pair holder, the bit count, the shift register, `run_len`, and the previous-bit register.
  - Flushes the FIFO: level becomes 0 and `byte_valid` becomes 0.
  - Does not clear `drop_cnt`.
  - Takes priority over `raw_valid`, `byte_ready`, and any push in the same cycle; all of these are ignored that cycle.
- **Priority order:** `rst` > `clear_fail` > health trip > sample processing.

## Timing
- A sample is accepted at edge N when `raw_valid = 1`.
- **Push latency.** If the sample at edge N completes a byte, then after edge N:
  - `byte_valid` = 1;
  - `byte_out` = that byte, if the FIFO was empty;
  - `fifo_level` is incremented.
- Single-cycle throughput: back-to-back `raw_valid` is supported, so at most one byte is pushed per cycle.
- **`byte_out` is show-ahead.** It changes only after a pop or after a push into an empty FIFO.
- **Health trip.** `health_fail` goes to 1 after the edge that accepts the `RCT_LIMIT`-th identical sample.
- **Clear.** `health_fail` returns to 0 after the edge where `clear_fail` = 1. A sample presented on the following cycle is the first sample of a new pair.
- **Reset mid-byte** discards the partial byte and all FIFO contents. No byte is produced from bits collected before reset.

## Test plan
- **All-ones byte.** Reset, then 16 samples alternating 1,0 with `byte_ready` = 1.
  - Expect `byte_valid` for one cycle with `byte_out` = 0xFF.
  - Expect `fifo_level` to return to 0 and `health_fail` to stay 0.
- **Mixed byte with discarded pairs.** Pairs 10,01,10,01,01,10,01,10, with pairs 00 and 11 interleaved between them, and `byte_ready` = 0.
  - Expect `byte_out` = 0xA5 and `fifo_level` = 1.
  - Expect no extra bits contributed by the 00 and 11 pairs.
- **Health trip and clear.** 16 consecutive samples of 1 (`RCT_LIMIT` = 16).
  - Expect `health_fail` = 1 after the 16th sample.
  - Then send 20 alternating samples: expect no push and `fifo_level` unchanged.
  - Pulse `clear_fail`: expect `health_fail` = 0 and the FIFO empty.
  - Then 16 alternating 1,0 samples: expect a push of 0xFF.
- **Overflow and drop count.** `byte_ready` = 0; generate 6 bytes.
  - Expect `fifo_level` = 4 and `drop_cnt` = 2, with the first 4 bytes popped in order.
  - Repeat with the FIFO full and `byte_ready` = 1 in the cycle the 5th byte completes: expect the level to stay 4 and `drop_cnt` to be unchanged.
- **Reset mid-byte.** Reset after 10 samples (5 emitted bits), then 16 alternating 0,1 samples.
  - Expect exactly one byte, 0x00, and `drop_cnt` = 0.
- **Clear collision.** Assert `clear_fail` in the same cycle as `raw_valid` completing a byte and `byte_ready` = 1 with `fifo_level` = 2.
  - Expect the FIFO empty afterwards, no push, and `drop_cnt` unchanged.

Source files
------------

// File: rtl/ttrng_collector.sv
// ttrng_collector: consumer side of the SR-latch TRNG.
// Samples raw bits, runs a repetition-count health test, debiases them with
// a von Neumann extractor, packs the result into bytes and buffers the bytes
// in a show-ahead FIFO with a valid/ready output handshake.
module ttrng_collector #(
    parameter int unsigned RCT_LIMIT  = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              raw_bit,
    input  logic                              raw_valid,
    input  logic                              clear_fail,
    output logic [7:0]                        byte_out,
    output logic                              byte_valid,
    input  logic                              byte_ready,
    output logic                              health_fail,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
    output logic [7:0]                        drop_cnt
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [7:0]    RCT_LIMIT8 = 8'(RCT_LIMIT);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

    // Health test state
    logic          health_fail_q, health_fail_d;
    logic          prev_bit_q,    prev_bit_d;
    logic          have_prev_q,   have_prev_d;
    logic [7:0]    run_len_q,     run_len_d;

    // Pair holder and byte packer
    logic          pair_bit_q,    pair_bit_d;
    logic          pair_full_q,   pair_full_d;
    logic [2:0]    bit_cnt_q,     bit_cnt_d;
    logic [7:0]    shreg_q,       shreg_d;

    // FIFO bookkeeping
    logic [AW-1:0] wr_ptr_q,      wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,      rd_ptr_d;
    logic [LW-1:0] level_q,       level_d;
    logic [7:0]    byte_out_q,    byte_out_d;
    logic          byte_valid_q,  byte_valid_d;
    logic [7:0]    drop_cnt_q,    drop_cnt_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    // Combinational helpers
    logic          pop;
    logic          push;
    logic          accept;
    logic          fifo_full;
    logic          emit;
    logic          emit_bit;
    logic [7:0]    run_next;
    logic [7:0]    push_byte;
    logic [AW-1:0] rd_next;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;

    assign byte_out    = byte_out_q;
    assign byte_valid  = byte_valid_q;
    assign health_fail = health_fail_q;
    assign fifo_level  = level_q;
    assign drop_cnt    = drop_cnt_q;

    // Next-state: clear, health test, pairing, packing and FIFO update
    always_comb begin
        health_fail_d = health_fail_q;
        prev_bit_d    = prev_bit_q;
        have_prev_d   = have_prev_q;
        run_len_d     = run_len_q;
        pair_bit_d    = pair_bit_q;
        pair_full_d   = pair_full_q;
        bit_cnt_d     = bit_cnt_q;
        shreg_d       = shreg_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        level_d       = level_q;
        byte_out_d    = byte_out_q;
        drop_cnt_d    = drop_cnt_q;
        pop           = 1'b0;
        push          = 1'b0;
        accept        = 1'b0;
        emit          = 1'b0;
        emit_bit      = 1'b0;
        run_next      = run_len_q;
        push_byte     = 8'h00;
        mem_we        = 1'b0;
        mem_waddr     = wr_ptr_q;
        mem_wdata     = 8'h00;
        fifo_full     = (level_q == FULL_LEVEL);
        rd_next       = rd_ptr_q + AW'(1);

        if (clear_fail) begin
            // Clear wins over every other activity this cycle
            health_fail_d = 1'b0;
            prev_bit_d    = 1'b0;
            have_prev_d   = 1'b0;
            run_len_d     = 8'h00;
            pair_bit_d    = 1'b0;
            pair_full_d   = 1'b0;
            bit_cnt_d     = 3'd0;
            shreg_d       = 8'h00;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            level_d       = '0;
        end else begin
            pop = (level_q != '0) && byte_ready;

            if (!health_fail_q && raw_valid) begin
                if (!have_prev_q || (raw_bit != prev_bit_q)) begin
                    run_next = 8'd1;
                end else if (run_len_q < RCT_LIMIT8) begin
                    run_next = run_len_q + 8'd1;
                end else begin
                    run_next = run_len_q;
                end
                run_len_d   = run_next;
                prev_bit_d  = raw_bit;
                have_prev_d = 1'b1;

                if (run_next == RCT_LIMIT8) begin
                    // The tripping sample never reaches the extractor
                    health_fail_d = 1'b1;
                end else if (!pair_full_q) begin
                    pair_bit_d  = raw_bit;
                    pair_full_d = 1'b1;
                end else begin
                    pair_full_d = 1'b0;
                    if (pair_bit_q != raw_bit) begin
                        emit     = 1'b1;
                        emit_bit = pair_bit_q;
                    end
                end
            end

            if (emit) begin
                shreg_d = {shreg_q[6:0], emit_bit};
                if (bit_cnt_q == 3'd7) begin
                    bit_cnt_d = 3'd0;
                    push      = 1'b1;
                    push_byte = {shreg_q[6:0], emit_bit};
                end else begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end

            if (push) begin
                if (!fifo_full || pop) begin
                    accept    = 1'b1;
                    mem_we    = 1'b1;
                    mem_wdata = push_byte;
                    wr_ptr_d  = wr_ptr_q + AW'(1);
                end else if (drop_cnt_q != 8'hFF) begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end
            end

            if (pop) begin
                rd_ptr_d = rd_next;
            end

            level_d = level_q + LW'(accept) - LW'(pop);

            // Show-ahead head only moves on a pop or a push into an empty FIFO
            if (pop) begin
                if (level_q > LW'(1)) begin
                    byte_out_d = mem_q[rd_next];
                end else if (accept) begin
                    byte_out_d = push_byte;
                end
            end else if (accept && (level_q == '0)) begin
                byte_out_d = push_byte;
            end
        end

        byte_valid_d = (level_d != '0);
    end

    // Control and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            health_fail_q <= 1'b0;
            prev_bit_q    <= 1'b0;
            have_prev_q   <= 1'b0;
            run_len_q     <= 8'h00;
            pair_bit_q    <= 1'b0;
            pair_full_q   <= 1'b0;
            bit_cnt_q     <= 3'd0;
            shreg_q       <= 8'h00;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            byte_out_q    <= 8'h00;
            byte_valid_q  <= 1'b0;
            drop_cnt_q    <= 8'h00;
        end else begin
            health_fail_q <= health_fail_d;
            prev_bit_q    <= prev_bit_d;
            have_prev_q   <= have_prev_d;
            run_len_q     <= run_len_d;
            pair_bit_q    <= pair_bit_d;
            pair_full_q   <= pair_full_d;
            bit_cnt_q     <= bit_cnt_d;
            shreg_q       <= shreg_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            byte_out_q    <= byte_out_d;
            byte_valid_q  <= byte_valid_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    // FIFO storage; contents are only meaningful below the level, so no reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_ttrng_collector.sv
// Randomized + directed bench for ttrng_collector with a queue-based
// reference model and a negedge monitor acting as scoreboard.
module tb_ttrng_collector;

    localparam int RCT   = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       raw_bit = 1'b0;
    logic       raw_valid = 1'b0;
    logic       clear_fail = 1'b0;
    logic       byte_ready = 1'b0;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       health_fail;
    logic [2:0] fifo_level;
    logic [7:0] drop_cnt;

    ttrng_collector #(.RCT_LIMIT(RCT), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .raw_bit    (raw_bit),
        .raw_valid  (raw_valid),
        .clear_fail (clear_fail),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .health_fail(health_fail),
        .fifo_level (fifo_level),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    logic [7:0] exp_q[$];
    logic       m_bits[$];
    int         m_level = 0;
    int         m_drop  = 0;
    int         m_run   = 0;
    int         m_prev  = -1;
    int         m_pend  = -1;
    bit         m_fail  = 0;
    int         pops    = 0;
    logic [7:0] last_pop = 8'h00;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model of one clock edge
    task automatic model_step(input logic v, input logic b, input logic r,
                              input logic c, input logic rs);
        bit         pop_now;
        bit         have_byte;
        logic [7:0] nb;
        have_byte = 0;
        nb        = 8'h00;
        if (rs) begin
            exp_q.delete(); m_bits.delete();
            m_level = 0; m_drop = 0; m_run = 0; m_prev = -1; m_pend = -1; m_fail = 0;
            return;
        end
        if (c) begin
            exp_q.delete(); m_bits.delete();
            m_level = 0; m_run = 0; m_prev = -1; m_pend = -1; m_fail = 0;
            return;
        end
        pop_now = (m_level > 0) && r;
        if (!m_fail && v) begin
            if (m_prev != int'(b)) m_run = 1;
            else if (m_run < RCT) m_run++;
            m_prev = int'(b);
            if (m_run == RCT) m_fail = 1;
            else if (m_pend < 0) m_pend = int'(b);
            else begin
                if (m_pend != int'(b)) m_bits.push_back(m_pend[0]);
                m_pend = -1;
            end
            if (m_bits.size() == 8) begin
                for (int i = 0; i < 8; i++) nb = {nb[6:0], m_bits[i]};
                m_bits.delete();
                have_byte = 1;
            end
        end
        if (have_byte) begin
            if (m_level < DEPTH || pop_now) begin
                exp_q.push_back(nb);
                if (!pop_now) m_level++;
            end else if (m_drop < 255) begin
                m_drop++;
            end
        end else if (pop_now) begin
            m_level--;
        end
    endtask

    // Monitor / scoreboard: compares status every cycle and pops on handshake
    always @(negedge clk) begin
        check("byte_valid", int'(byte_valid), int'(m_level > 0));
        check("fifo_level", int'(fifo_level), m_level);
        check("health_fail", int'(health_fail), int'(m_fail));
        check("drop_cnt", int'(drop_cnt), m_drop);
        if (byte_valid) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL scoreboard: byte_valid with byte 0x%0h but no byte expected", byte_out);
            end else begin
                check("byte_out", int'(byte_out), int'(exp_q[0]));
                if (byte_ready && !clear_fail && !rst) begin
                    last_pop = exp_q.pop_front();
                    pops++;
                end
            end
        end
    end

    task automatic cyc(input logic v, input logic b, input logic r, input logic c);
        raw_valid = v; raw_bit = b; byte_ready = r; clear_fail = c;
        @(posedge clk);
        model_step(v, b, r, c, rst);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        rst = 1'b0;
    endtask

    task automatic sample(input logic b, input logic r);
        cyc(1, b, r, 0);
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) cyc(0, 0, r, 0);
    endtask

    // One emitted bit e uses the pair (e, ~e)
    task automatic send_bit(input logic e, input logic r1, input logic r2);
        sample(e, r1);
        sample(~e, r2);
    endtask

    task automatic send_byte(input logic [7:0] val, input logic r_all, input logic r_last);
        for (int i = 7; i >= 0; i--)
            send_bit(val[i], r_all, (i == 0) ? r_last : r_all);
    endtask

    initial begin
        int         p0;
        logic [7:0] a5;
        logic [7:0] v;
        int         stuck;

        // Reset state
        do_reset();
        check("rst_byte_out", int'(byte_out), 0);
        check("rst_level", int'(fifo_level), 0);

        // All-ones byte
        p0 = pops;
        send_byte(8'hFF, 1, 1);
        idle(3, 1);
        check("ones_pops", pops - p0, 1);
        check("ones_byte", int'(last_pop), 8'hFF);
        check("ones_level", int'(fifo_level), 0);
        check("ones_health", int'(health_fail), 0);

        // Mixed byte with discarded pairs interleaved
        do_reset();
        a5 = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            send_bit(a5[i], 0, 0);
            if (i % 2 == 0) begin sample(0, 0); sample(0, 0); end
            else            begin sample(1, 0); sample(1, 0); end
        end
        idle(2, 0);
        check("mixed_byte", int'(byte_out), 8'hA5);
        check("mixed_level", int'(fifo_level), 1);

        // Health trip and clear
        do_reset();
        send_byte(8'h3C, 0, 0);
        for (int i = 0; i < 16; i++) sample(1, 0);
        check("trip_health", int'(health_fail), 1);
        for (int i = 0; i < 20; i++) sample(i[0], 0);
        check("trip_level", int'(fifo_level), 1);
        cyc(0, 0, 0, 1);
        check("clear_health", int'(health_fail), 0);
        check("clear_valid", int'(byte_valid), 0);
        p0 = pops;
        send_byte(8'hFF, 1, 1);
        idle(3, 1);
        check("clear_pops", pops - p0, 1);
        check("clear_byte", int'(last_pop), 8'hFF);

        // Overflow and drop count
        do_reset();
        for (int i = 0; i < 6; i++) send_byte(8'($urandom), 0, 0);
        check("ovf_level", int'(fifo_level), 4);
        check("ovf_drop", int'(drop_cnt), 2);
        p0 = pops;
        idle(6, 1);
        check("ovf_pops", pops - p0, 4);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0, 0);
        send_byte(8'h5A, 0, 1);
        check("ovf_full_pop_level", int'(fifo_level), 4);
        check("ovf_full_pop_drop", int'(drop_cnt), 2);
        idle(6, 1);

        // Reset mid-byte
        do_reset();
        for (int i = 0; i < 10; i++) sample(~i[0], 0);
        do_reset();
        p0 = pops;
        send_byte(8'h00, 1, 1);
        idle(3, 1);
        check("midrst_pops", pops - p0, 1);
        check("midrst_byte", int'(last_pop), 0);
        check("midrst_drop", int'(drop_cnt), 0);

        // Clear colliding with a byte completion and a pop
        do_reset();
        send_byte(8'h11, 0, 0);
        send_byte(8'h22, 0, 0);
        v = 8'h33;
        for (int i = 7; i >= 1; i--) send_bit(v[i], 0, 0);
        sample(v[0], 0);
        check("coll_pre_level", int'(fifo_level), 2);
        cyc(1, ~v[0], 1, 1);
        check("coll_level", int'(fifo_level), 0);
        check("coll_valid", int'(byte_valid), 0);
        check("coll_drop", int'(drop_cnt), 0);
        idle(2, 1);

        // Randomized traffic with occasional stuck-at runs and clears
        do_reset();
        stuck = 0;
        for (int i = 0; i < 4000; i++) begin
            if (stuck == 0 && $urandom_range(0, 399) == 0) stuck = 24;
            if (m_fail && $urandom_range(0, 15) == 0) begin
                cyc(0, 0, 1'($urandom), 1);
            end else begin
                cyc(1'($urandom_range(0, 3) != 0),
                    (stuck > 0) ? 1'b1 : 1'($urandom),
                    1'($urandom_range(0, 2) == 0),
                    1'($urandom_range(0, 499) == 0));
            end
            if (stuck > 0) stuck--;
        end
        idle(8, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
